// File: rtl/calc_pipe.sv
// Two-stage ALU pipeline: S1 pre-processes operands (zero/invert), S2 does add/and and optional output invert.
// Define CALC_PIPE_CARRY_EN to add the registered adder carry-out port.
module calc_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       cb,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] acc
`ifdef CALC_PIPE_CARRY_EN
  ,
  output logic             carry
`endif
);

  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic             s1_load, s2_load, accept;
  logic [WIDTH-1:0] xsrc, xa_d, ya_d;
  logic [WIDTH-1:0] s1_xa, s1_ya;
  logic             s1_f, s1_no;
  logic [WIDTH-1:0] r, res;

  assign s2_load   = !vld_pipe[2] || out_ready;
  assign s1_load   = !vld_pipe[1] || s2_load;
  // An acc_sel op must not enter S1 while the op producing acc is still in S1.
  assign in_ready  = s1_load && !(acc_sel && vld_pipe[1]);
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[2];
  assign xsrc      = acc_sel ? acc : x;

  always_comb begin
    xa_d = cb[5] ? '0 : xsrc;
    if (cb[4]) xa_d = ~xa_d;
    ya_d = cb[3] ? '0 : y;
    if (cb[2]) ya_d = ~ya_d;
  end

`ifdef CALC_PIPE_CARRY_EN
  logic [WIDTH:0] sum;
  assign sum = {1'b0, s1_xa} + {1'b0, s1_ya};
`else
  logic [WIDTH-1:0] sum;
  assign sum = s1_xa + s1_ya;
`endif

  assign r   = s1_f ? sum[WIDTH-1:0] : (s1_xa & s1_ya);
  assign res = s1_no ? ~r : r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_xa    <= '0;
      s1_ya    <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
      out      <= '0;
      zr       <= 1'b0;
      ng       <= 1'b0;
      acc      <= '0;
`ifdef CALC_PIPE_CARRY_EN
      carry    <= 1'b0;
`endif
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= accept;
        if (accept) begin
          s1_xa <= xa_d;
          s1_ya <= ya_d;
          s1_f  <= cb[1];
          s1_no <= cb[0];
        end
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out   <= res;
          zr    <= (res == '0);
          ng    <= res[WIDTH-1];
          acc   <= res;
`ifdef CALC_PIPE_CARRY_EN
          carry <= s1_f & sum[WIDTH];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_pipe.sv
// Self-checking bench for calc_pipe: directed vectors, hand sequences for stalls/hazard/reset,
// then random traffic scored against an arithmetic reference model.
module tb_calc_pipe;

  localparam int  W = 16;
  localparam longint M = 65536;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, acc_sel, out_valid, out_ready, zr, ng;
  logic [W-1:0] x, y, out, acc;
  logic [5:0]   cb;
  logic         carry_w;

  calc_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cb(cb), .acc_sel(acc_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zr(zr), .ng(ng), .acc(acc)
`ifdef CALC_PIPE_CARRY_EN
    , .carry(carry_w)
`endif
  );
`ifndef CALC_PIPE_CARRY_EN
  assign carry_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: spec rules as plain integer arithmetic.
  function automatic longint model(input logic [5:0] c, input longint xs, input longint ys,
                                   output bit cy);
    longint a, b, r;
    a = c[5] ? 0 : xs;
    if (c[4]) a = M - 1 - a;
    b = c[3] ? 0 : ys;
    if (c[2]) b = M - 1 - b;
    if (c[1]) begin
      r  = a + b;
      cy = (r >= M);
      r  = r % M;
    end else begin
      r  = a & b;
      cy = 1'b0;
    end
    if (c[0]) r = M - 1 - r;
    return r;
  endfunction

  typedef struct {
    logic [5:0]   cb;
    logic [W-1:0] x, y, out;
    logic         zr, ng, c;
  } vec_t;

  typedef struct {
    logic [W-1:0] out;
    logic         c;
  } exp_t;

  vec_t   tbl[6];
  exp_t   q[$];
  longint model_acc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One random/drain cycle: score transfers, track held results, enqueue accepted ops.
  bit           held;
  logic [W-1:0] held_out;
  task automatic mon_cycle;
    exp_t e;
    bit   cy;
    @(negedge clk);
    if (held) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_stable", out, held_out);
    end
    held     = out_valid && !out_ready;
    held_out = out;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_result", 1'b1, 1'b0);
      else begin
        e = q.pop_front();
        chk("rnd_out", out, e.out);
        chk("rnd_zr", zr, e.out == 0);
        chk("rnd_ng", ng, e.out[W-1]);
        chk("rnd_acc", acc, e.out);
`ifdef CALC_PIPE_CARRY_EN
        chk("rnd_carry", carry_w, e.c);
`endif
      end
    end
    if (in_valid && in_ready) begin
      e.out     = W'(model(cb, acc_sel ? model_acc : longint'(x), longint'(y), cy));
      e.c       = cy;
      model_acc = longint'(e.out);
      q.push_back(e);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int k, n, stale;
    bit a;
    logic [W-1:0] got[3];

    tbl[0] = '{6'b101010, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{6'b000010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{6'b010011, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{6'b110111, 16'h0003, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{6'b000000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{6'b000001, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 0; acc_sel = 0; out_ready = 0; cb = '0; x = '0; y = '0;
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_acc", acc, 16'h0);
    chk("rst_out", out, 16'h0);
    chk("rst_zr", zr, 1'b0);
    chk("rst_ng", ng, 1'b0);
    #4 rst_n = 1'b1;

    // Directed vectors, one at a time, also checking 2-edge latency.
    foreach (tbl[i]) begin
      in_valid = 1; out_ready = 1; acc_sel = 0;
      cb = tbl[i].cb; x = tbl[i].x; y = tbl[i].y;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
      tick();
      in_valid = 0;
      @(negedge clk);
      chk($sformatf("v%0d_early_valid", i), out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("v%0d_out", i), out, tbl[i].out);
      chk($sformatf("v%0d_zr", i), zr, tbl[i].zr);
      chk($sformatf("v%0d_ng", i), ng, tbl[i].ng);
`ifdef CALC_PIPE_CARRY_EN
      chk($sformatf("v%0d_carry", i), carry_w, tbl[i].c);
`endif
      tick();
    end

    // Backpressure: three back-to-back ops against a stalled output.
    out_ready = 0; k = 0; in_valid = 1; cb = 6'b000010; x = 1; y = 1;
    repeat (4) begin
      @(negedge clk);
      a = in_valid && in_ready;
      tick();
      if (a) begin
        k++;
        if (k < 3) begin x = W'(k + 1); y = W'(k + 1); end
        else in_valid = 0;
      end
    end
    @(negedge clk);
    chk("bp_accepted", k, 2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_held_out", out, 16'd2);
    tick();
    out_ready = 1; n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      a = in_valid && in_ready;
      if (out_valid) begin got[n] = out; n++; end
      tick();
      if (a) begin
        k++;
        if (k < 3) begin x = W'(k + 1); y = W'(k + 1); end
        else in_valid = 0;
      end
    end
    in_valid = 0;
    chk("bp_count", n, 3);
    chk("bp_r0", got[0], 16'd2);
    chk("bp_r1", got[1], 16'd4);
    chk("bp_r2", got[2], 16'd6);

    // Accumulator hazard.
    in_valid = 1; acc_sel = 0; cb = 6'b000010; x = 16'h0002; y = 16'h0003;
    @(negedge clk);
    chk("hz_a_ready", in_ready, 1'b1);
    tick();
    acc_sel = 1; x = 16'h7777; y = 16'h0001;
    @(negedge clk);
    chk("hz_stall", in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("hz_b_ready", in_ready, 1'b1);
    chk("hz_acc", acc, 16'h0005);
    tick();
    in_valid = 0; acc_sel = 0;
    @(negedge clk);
    chk("hz_gap", out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("hz_b_valid", out_valid, 1'b1);
    chk("hz_b_out", out, 16'h0006);
    tick();

    // Asynchronous reset with two ops in flight.
    out_ready = 0; in_valid = 1; cb = 6'b000010; x = 1; y = 1;
    tick();
    tick();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_acc", acc, 16'h0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_zr", zr, 1'b0);
    #3 rst_n = 1;
    out_ready = 1; stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("ar_stale", stale, 0);
    tick();

    // Random traffic against the model.
    model_acc = 0; held = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      acc_sel   = ($urandom_range(0, 3) == 0);
      cb        = 6'($urandom);
      x         = W'($urandom);
      y         = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      mon_cycle();
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 20 && q.size() != 0; c++) mon_cycle();
    chk("rnd_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_pipe.md
CALC_PIPE -- requirements
Module: calc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready at a clk edge.
REQ-006 SHALL have port x  input  WIDTH  operand X.
REQ-007 SHALL have port y  input  WIDTH  operand Y.
REQ-008 SHALL have port cb  input  6  control bits {zx,nx,zy,ny,f,no}, where cb[5]=zx and cb[0]=no.
REQ-009 SHALL have port acc_sel  input  1  when 1, use internal accumulator instead of x.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port out  output  WIDTH  result.
REQ-013 SHALL have port zr  output  1  out == 0.
REQ-014 SHALL have port ng  output  1  out[WIDTH-1].
REQ-015 SHALL have port acc  output  WIDTH  accumulator value.
REQ-016 SHALL have port carry  output  1  adder carry-out; present only with CALC_PIPE_CARRY_EN.

Function
REQ-017 SHALL be a two-stage pipeline: S1 holds pre-processed operands plus f/no; S2 holds out/flags; latency 2 edges from acceptance to out_valid, with no bubbles at full throughput.
REQ-018 S1 SHALL capture xa = zx ? 0 : xsrc, then nx inverts xa; likewise for y with zy/ny; xsrc = acc_sel ? acc : x; all operations act on all WIDTH bits.
REQ-019 S2 SHALL compute r = f ? (xa + ya) mod 2^WIDTH : (xa & ya), then out = no ? ~r : r; zr/ng SHALL be derived from the registered out.
REQ-020 S2 SHALL load when !out_valid || out_ready; S1 SHALL load when !s1_valid || S2 loads; on load with no valid source, the stage valid SHALL clear.
REQ-021 SHALL drive in_ready = S1-load && !(acc_sel && s1_valid), an accumulator hazard interlock; in_ready SHALL NOT depend on in_valid.
REQ-022 acc SHALL update to the S2 result on the edge S2 loads a valid operation, independent of out_ready.
REQ-023 Under a held result (out_valid=1, out_ready=0), out/zr/ng/carry SHALL stay stable; with both stages full, in_ready=0.
REQ-024 Results SHALL emerge in acceptance order with no loss or duplication.
REQ-025 When out transfers and a new S2 load occurs on the same edge, there SHALL be no bubble.

Reset
REQ-026 rst_n=0 SHALL immediately clear S1/S2 valids, out, zr (to 0), ng, carry and acc; in-flight operations SHALL be discarded.
REQ-027 in_ready SHALL be 1 during and after reset; the first acceptance SHALL be possible on the first edge with rst_n=1.

Configuration
REQ-028 With CALC_PIPE_CARRY_EN defined, carry SHALL be registered in S2 as the adder carry-out when f=1 and 0 when f=0, unaffected by no.
REQ-029 Without CALC_PIPE_CARRY_EN, the carry port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=16)
REQ-030 cb=101010, x=1234, y=5678 -> out=0000, zr=1, ng=0, out_valid 2 edges after acceptance.
REQ-031 cb=000010, x=FFFF, y=0001 -> out=0000, zr=1; carry=1 with the macro defined.
REQ-032 cb=010011, x=0003, y=0005 -> out=FFFE, ng=1, zr=0; cb=110111, y=0000 -> out=0001.
REQ-033 Hold out_ready=0 and offer 3 back-to-back ops -> 2 accepted, then in_ready=0; after out_ready=1, all 3 results appear in order, unchanged.
REQ-034 Op A: cb=000010, x=0002, y=0003. Next cycle, op B: acc_sel=1, cb=000010, y=0001 -> in_ready=0 for one cycle, acc=0005, B result=0006.
REQ-035 Pulse rst_n low with 2 ops in flight -> out_valid=0 and acc=0000 without a clk edge; no stale result appears after release.
